// File: rtl/sha256_job_arbiter.sv
// Round-robin arbiter sharing one sha256_transform between NUM_REQ requesters.
// Forwards the granted requester's context and chunks, then returns the tagged hash.
package sha256_pkg;
  typedef struct packed {
    logic [7:0][31:0] h;
    logic [63:0]      msg_len;
  } ShaContext;
endpackage

module sha256_job_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ),
  parameter int CNT_W   = 8
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_REQ-1:0]                   req_vld,
  output logic [NUM_REQ-1:0]                   req_rdy,
  input  sha256_pkg::ShaContext [NUM_REQ-1:0]  req_ctx,
  input  logic [NUM_REQ-1:0][CNT_W-1:0]        req_nchunks,
  input  logic [NUM_REQ-1:0]                   req_chunk_vld,
  output logic [NUM_REQ-1:0]                   req_chunk_rdy,
  input  logic [NUM_REQ-1:0][15:0][31:0]       req_chunk_data,
  output logic                                 xf_ctx_vld,
  input  logic                                 xf_ctx_rdy,
  output sha256_pkg::ShaContext                xf_ctx,
  output logic                                 xf_chunk_vld,
  input  logic                                 xf_chunk_rdy,
  output logic [15:0][31:0]                    xf_chunk_data,
  input  logic                                 xf_hash_vld,
  output logic                                 xf_hash_rdy,
  input  logic [255:0]                         xf_hash,
  output logic                                 rsp_vld,
  input  logic                                 rsp_rdy,
  output logic [ID_W-1:0]                      rsp_id,
  output logic [255:0]                         rsp_hash,
  output logic                                 busy,
  output logic [31:0]                          jobs_done
);

  typedef enum logic [2:0] {IDLE, CTX, CHUNK, WAIT, RESP} state_t;

  state_t            state, state_nx;
  logic [ID_W-1:0]   gnt_id;
  logic [ID_W-1:0]   last_id;
  logic [ID_W-1:0]   sel_id;
  logic [ID_W-1:0]   cand;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  sel_nchunks;
  logic              ctx_hs;
  logic              chunk_hs;

  // Scan from farthest to nearest so the requester closest after last_id wins.
  always_comb begin
    sel_id = '0;
    cand   = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = ID_W'((int'(last_id) + k) % NUM_REQ);
      if (req_vld[cand]) sel_id = cand;
    end
    sel_nchunks = req_nchunks[sel_id];
  end

  always_comb begin
    state_nx      = state;
    req_rdy       = '0;
    req_chunk_rdy = '0;
    xf_ctx_vld    = 1'b0;
    xf_ctx        = '0;
    xf_chunk_vld  = 1'b0;
    xf_chunk_data = '0;
    xf_hash_rdy   = 1'b0;
    rsp_vld       = 1'b0;
    rsp_id        = '0;
    case (state)
      IDLE: begin
        if (|req_vld) state_nx = CTX;
      end
      CTX: begin
        xf_ctx_vld      = req_vld[gnt_id];
        xf_ctx          = req_ctx[gnt_id];
        req_rdy[gnt_id] = xf_ctx_rdy;
        if (req_vld[gnt_id] && xf_ctx_rdy) state_nx = CHUNK;
      end
      CHUNK: begin
        xf_chunk_vld          = req_chunk_vld[gnt_id];
        xf_chunk_data         = req_chunk_data[gnt_id];
        req_chunk_rdy[gnt_id] = xf_chunk_rdy;
        if (req_chunk_vld[gnt_id] && xf_chunk_rdy && cnt == CNT_W'(1)) state_nx = WAIT;
      end
      WAIT: begin
        xf_hash_rdy = 1'b1;
        if (xf_hash_vld) state_nx = RESP;
      end
      RESP: begin
        rsp_vld = 1'b1;
        rsp_id  = gnt_id;
        if (rsp_rdy) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign ctx_hs   = xf_ctx_vld && xf_ctx_rdy;
  assign chunk_hs = xf_chunk_vld && xf_chunk_rdy;
  assign busy     = (state != IDLE);

  // last_id resets to the top index so the first grant lands on requester 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      last_id   <= ID_W'(NUM_REQ - 1);
      gnt_id    <= '0;
      cnt       <= '0;
      rsp_hash  <= '0;
      jobs_done <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (|req_vld) begin
            gnt_id <= sel_id;
            cnt    <= (sel_nchunks == '0) ? CNT_W'(1) : sel_nchunks;
          end
        end
        CHUNK: begin
          if (chunk_hs) cnt <= cnt - CNT_W'(1);
        end
        WAIT: begin
          if (xf_hash_vld) rsp_hash <= xf_hash;
        end
        RESP: begin
          if (rsp_rdy) begin
            last_id   <= gnt_id;
            jobs_done <= jobs_done + 32'd1;
          end
        end
        default: ;
      endcase
    end
  end

  logic unused_ok;
  assign unused_ok = ctx_hs;

endmodule

// File: tb/tb_sha256_job_arbiter.sv
// Bench for sha256_job_arbiter: bench-side requesters and transform, with a
// round-robin reference model predicting grant order and tagged responses.
module tb_sha256_job_arbiter;
  import sha256_pkg::*;

  localparam int N = 4;

  logic                     clk, rst;
  logic [N-1:0]             req_vld, req_rdy, req_chunk_vld, req_chunk_rdy;
  ShaContext [N-1:0]        req_ctx;
  logic [N-1:0][7:0]        req_nchunks;
  logic [N-1:0][15:0][31:0] req_chunk_data;
  logic                     xf_ctx_vld, xf_ctx_rdy;
  ShaContext                xf_ctx;
  logic                     xf_chunk_vld, xf_chunk_rdy;
  logic [15:0][31:0]        xf_chunk_data;
  logic                     xf_hash_vld, xf_hash_rdy;
  logic [255:0]             xf_hash;
  logic                     rsp_vld, rsp_rdy;
  logic [1:0]               rsp_id;
  logic [255:0]             rsp_hash;
  logic                     busy;
  logic [31:0]              jobs_done;

  sha256_job_arbiter #(.NUM_REQ(N), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .req_vld(req_vld), .req_rdy(req_rdy), .req_ctx(req_ctx), .req_nchunks(req_nchunks),
    .req_chunk_vld(req_chunk_vld), .req_chunk_rdy(req_chunk_rdy), .req_chunk_data(req_chunk_data),
    .xf_ctx_vld(xf_ctx_vld), .xf_ctx_rdy(xf_ctx_rdy), .xf_ctx(xf_ctx),
    .xf_chunk_vld(xf_chunk_vld), .xf_chunk_rdy(xf_chunk_rdy), .xf_chunk_data(xf_chunk_data),
    .xf_hash_vld(xf_hash_vld), .xf_hash_rdy(xf_hash_rdy), .xf_hash(xf_hash),
    .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_id(rsp_id), .rsp_hash(rsp_hash),
    .busy(busy), .jobs_done(jobs_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { int id; logic [255:0] h; } rsp_t;

  int checks = 0;
  int errors = 0;

  bit want[N];
  bit active[N];
  int nch[N];
  bit rearm, rand_mode, chunk_offer, hash_auto;
  int ctx_pol, chunk_pol, rsp_pol;
  int cyc, last_model, pend_gnt, owner, job_n, job_chunks, hash_delay;
  bit hash_done;
  int ctx_hs_n, chunk_hs_n, rsp_n, bad_rdy, data_err, stab_err, early_err;
  int req_cyc, ctx_cyc, hash_cyc, rsp_cyc;
  int grant_log[$];
  int exp_grant[$];
  rsp_t exp_rsp[$];
  rsp_t obs_rsp[$];
  bit prev_stall;
  logic [15:0][31:0] prev_data;

  function automatic logic [255:0] rand256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [511:0] rand512();
    return {rand256(), rand256()};
  endfunction

  // Lowest requester strictly after the last served one, wrapping.
  function automatic int rr_pick(int last, logic [N-1:0] v);
    for (int k = 1; k <= N; k++)
      if (v[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  task automatic set_job(int r, int n);
    ShaContext c;
    c.h            = rand256();
    c.msg_len      = {$urandom, $urandom};
    want[r]        = 1'b1;
    nch[r]         = n;
    req_ctx[r]     = c;
    req_nchunks[r] = 8'(n);
    req_chunk_data[r] = rand512();
  endtask

  task automatic drive();
    for (int r = 0; r < N; r++) begin
      req_vld[r]       = want[r] && !active[r];
      req_chunk_vld[r] = active[r] && chunk_offer;
    end
  endtask

  task automatic model_clear();
    for (int r = 0; r < N; r++) begin
      want[r] = 1'b0; active[r] = 1'b0; nch[r] = 0;
    end
    rearm = 0; rand_mode = 0; chunk_offer = 1; hash_auto = 1;
    ctx_pol = 0; chunk_pol = 0; rsp_pol = 0;
    cyc = 0; last_model = N - 1; pend_gnt = -1; owner = -1;
    job_n = 0; job_chunks = 0; hash_delay = 0; hash_done = 0;
    ctx_hs_n = 0; chunk_hs_n = 0; rsp_n = 0;
    bad_rdy = 0; data_err = 0; stab_err = 0; early_err = 0;
    req_cyc = -1; ctx_cyc = -1; hash_cyc = -1; rsp_cyc = -1;
    grant_log.delete(); exp_grant.delete(); exp_rsp.delete(); obs_rsp.delete();
    prev_stall = 0; prev_data = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_ctx = '0; req_nchunks = '0; req_chunk_data = '0;
    req_vld = '0; req_chunk_vld = '0;
    xf_ctx_rdy = 1'b0; xf_chunk_rdy = 1'b0; xf_hash_vld = 1'b0; xf_hash = '0; rsp_rdy = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    drive();
  endtask

  // One clock: observe at the falling edge, update bench agents just after the rising edge.
  task automatic tick();
    logic ctx_hs, chk_hs, hash_hs, rsp_hs;
    int g;
    @(negedge clk);
    cyc++;
    g = -1;
    if (!busy && (req_vld != '0)) begin
      pend_gnt = rr_pick(last_model, req_vld);
      exp_grant.push_back(pend_gnt);
      req_cyc = cyc;
    end
    if (req_rdy != '0 && (pend_gnt < 0 || req_rdy != (4'b1 << pend_gnt))) bad_rdy++;
    if (req_chunk_rdy != '0 && (owner < 0 || req_chunk_rdy != (4'b1 << owner))) bad_rdy++;
    if (xf_ctx_vld && ctx_cyc < req_cyc) ctx_cyc = cyc;
    ctx_hs = xf_ctx_vld && xf_ctx_rdy;
    if (ctx_hs) begin
      for (int r = 0; r < N; r++) if (req_rdy[r]) g = r;
      ctx_hs_n++;
      if (g < 0) data_err++;
      else begin
        grant_log.push_back(g);
        if (xf_ctx !== req_ctx[g]) data_err++;
      end
    end
    chk_hs = xf_chunk_vld && xf_chunk_rdy;
    if (chk_hs) begin
      chunk_hs_n++;
      if (owner < 0 || xf_chunk_data !== req_chunk_data[owner]) data_err++;
    end
    if (prev_stall && xf_chunk_vld && xf_chunk_data !== prev_data) stab_err++;
    prev_stall = xf_chunk_vld && !xf_chunk_rdy;
    prev_data  = xf_chunk_data;
    if (xf_hash_rdy && (owner < 0 || job_chunks < job_n)) early_err++;
    hash_hs = xf_hash_vld && xf_hash_rdy;
    if (hash_hs) begin
      exp_rsp.push_back('{pend_gnt, xf_hash});
      hash_cyc = cyc;
    end
    if (rsp_vld && rsp_cyc < hash_cyc) rsp_cyc = cyc;
    rsp_hs = rsp_vld && rsp_rdy;
    if (rsp_hs) begin
      obs_rsp.push_back('{int'(rsp_id), rsp_hash});
      rsp_n++;
    end
    @(posedge clk);
    #1;
    if (ctx_hs && g >= 0) begin
      active[g] = 1'b1; owner = g;
      job_n = (nch[g] == 0) ? 1 : nch[g];
      job_chunks = 0; hash_done = 0; hash_delay = $urandom_range(0, 2);
    end
    if (chk_hs && owner >= 0) begin
      job_chunks++;
      req_chunk_data[owner] = rand512();
    end
    if (hash_hs) begin
      xf_hash_vld = 1'b0; hash_done = 1'b1;
    end
    if (rsp_hs) begin
      if (pend_gnt >= 0) begin
        active[pend_gnt] = 1'b0;
        want[pend_gnt]   = rearm;
        if (rearm) set_job(pend_gnt, nch[pend_gnt]);
      end
      last_model = pend_gnt;
      owner = -1;
    end
    if (rand_mode)
      for (int r = 0; r < N; r++)
        if (!want[r] && $urandom_range(0, 5) == 0) set_job(r, $urandom_range(0, 4));
    if (hash_auto && owner >= 0 && !hash_done && !xf_hash_vld && job_chunks >= job_n) begin
      if (hash_delay == 0) begin
        xf_hash_vld = 1'b1; xf_hash = rand256();
      end else hash_delay--;
    end
    xf_ctx_rdy   = (ctx_pol == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    case (chunk_pol)
      0:       xf_chunk_rdy = 1'b1;
      1:       xf_chunk_rdy = 1'($urandom_range(0, 1));
      default: xf_chunk_rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
    endcase
    case (rsp_pol)
      0:       rsp_rdy = 1'b1;
      1:       rsp_rdy = 1'($urandom_range(0, 1));
      default: rsp_rdy = 1'b0;
    endcase
    drive();
  endtask

  task automatic run_until(int target, int budget, output bit to);
    while (rsp_n < target && budget > 0) begin
      tick();
      budget--;
    end
    to = (rsp_n < target);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", busy); end
    checks++;
    if ({xf_ctx_vld, xf_chunk_vld, xf_hash_rdy, rsp_vld} !== 4'b0) begin
      errors++; $display("FAIL reset_vld: got %b expected 0000", {xf_ctx_vld, xf_chunk_vld, xf_hash_rdy, rsp_vld});
    end
    checks++;
    if ({req_rdy, req_chunk_rdy} !== 8'b0) begin
      errors++; $display("FAIL reset_rdy: got %b expected 0", {req_rdy, req_chunk_rdy});
    end
    checks++;
    if (jobs_done !== 32'd0) begin errors++; $display("FAIL reset_jobs: got %0d expected 0", jobs_done); end
    checks++;
    if (rsp_hash !== 256'd0) begin errors++; $display("FAIL reset_hash: got %0h expected 0", rsp_hash); end
  endtask

  task automatic test_single_job();
    bit to;
    do_reset();
    set_job(2, 3);
    drive();
    run_until(1, 200, to);
    checks++;
    if (to) begin errors++; $display("FAIL single_timeout: got %0d responses expected 1", rsp_n); end
    checks++;
    if (ctx_hs_n !== 1) begin errors++; $display("FAIL single_ctx_hs: got %0d expected 1", ctx_hs_n); end
    checks++;
    if (chunk_hs_n !== 3) begin errors++; $display("FAIL single_chunk_hs: got %0d expected 3", chunk_hs_n); end
    checks++;
    if (obs_rsp.size() != 1 || exp_rsp.size() != 1) begin
      errors++; $display("FAIL single_rsp_count: got %0d expected 1", obs_rsp.size());
    end else begin
      if (obs_rsp[0].id != 2) begin errors++; $display("FAIL single_rsp_id: got %0d expected 2", obs_rsp[0].id); end
      checks++;
      if (obs_rsp[0].h !== exp_rsp[0].h) begin
        errors++; $display("FAIL single_rsp_hash: got %0h expected %0h", obs_rsp[0].h, exp_rsp[0].h);
      end
    end
    checks++;
    if (rsp_cyc - hash_cyc != 1) begin errors++; $display("FAIL single_hash_lat: got %0d expected 1", rsp_cyc - hash_cyc); end
    checks++;
    if (ctx_cyc - req_cyc != 1) begin errors++; $display("FAIL single_ctx_lat: got %0d expected 1", ctx_cyc - req_cyc); end
    checks++;
    if (jobs_done !== 32'd1) begin errors++; $display("FAIL single_jobs: got %0d expected 1", jobs_done); end
    checks++;
    if (data_err != 0) begin errors++; $display("FAIL single_data: got %0d errors expected 0", data_err); end
  endtask

  task automatic test_fairness();
    int exp_tbl[6] = '{0, 1, 2, 3, 0, 1};
    bit to;
    do_reset();
    rearm = 1;
    for (int r = 0; r < N; r++) set_job(r, 1);
    drive();
    run_until(6, 400, to);
    checks++;
    if (to || grant_log.size() < 6) begin
      errors++; $display("FAIL fair_timeout: got %0d grants expected 6", grant_log.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (grant_log[i] != exp_tbl[i]) begin
          errors++; $display("FAIL fair_order[%0d]: got %0d expected %0d", i, grant_log[i], exp_tbl[i]);
        end
      end
    end
    checks++;
    if (bad_rdy != 0) begin errors++; $display("FAIL fair_rdy: got %0d stray rdy cycles expected 0", bad_rdy); end
  endtask

  task automatic test_backpressure();
    logic [255:0] h0;
    int n;
    bit to;
    do_reset();
    chunk_pol = 2; rsp_pol = 2;
    set_job(1, 3);
    drive();
    n = 0;
    while (!rsp_vld && n < 200) begin tick(); n++; end
    checks++;
    if (!rsp_vld) begin errors++; $display("FAIL bp_timeout: got rsp_vld=0 expected 1"); end
    h0 = rsp_hash;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (!(rsp_vld === 1'b1 && busy === 1'b1 && rsp_hash === h0)) begin
        errors++; $display("FAIL bp_hold[%0d]: got vld=%0b hash=%0h expected vld=1 hash=%0h", i, rsp_vld, rsp_hash, h0);
      end
    end
    checks++;
    if (chunk_hs_n != 3 || stab_err != 0 || early_err != 0) begin
      errors++; $display("FAIL bp_chunks: got hs=%0d stab=%0d early=%0d expected 3/0/0", chunk_hs_n, stab_err, early_err);
    end
    checks++;
    if (exp_rsp.size() != 1 || h0 !== exp_rsp[0].h) begin
      errors++; $display("FAIL bp_hash: got %0h expected transform hash", h0);
    end
    rsp_pol = 0;
    run_until(1, 20, to);
    checks++;
    if (to || jobs_done !== 32'd1) begin errors++; $display("FAIL bp_release: got jobs %0d expected 1", jobs_done); end
  endtask

  task automatic test_zero_count();
    bit to;
    do_reset();
    set_job(3, 0);
    drive();
    run_until(1, 200, to);
    checks++;
    if (to || chunk_hs_n != 1) begin errors++; $display("FAIL zero_chunks: got %0d expected 1", chunk_hs_n); end
    checks++;
    if (early_err != 0) begin errors++; $display("FAIL zero_early: got %0d expected 0", early_err); end
    checks++;
    if (obs_rsp.size() != 1 || obs_rsp[0].id != 3) begin
      errors++; $display("FAIL zero_rsp_id: got %0d responses expected one for id 3", obs_rsp.size());
    end
  endtask

  task automatic test_stray_hash();
    logic [255:0] stray;
    int n;
    bit to;
    do_reset();
    chunk_offer = 0; hash_auto = 0;
    set_job(0, 2);
    drive();
    n = 0;
    while (owner < 0 && n < 50) begin tick(); n++; end
    tick();
    checks++;
    if (busy !== 1'b1 || owner != 0) begin errors++; $display("FAIL stray_setup: got busy=%0b owner=%0d expected 1/0", busy, owner); end
    stray = rand256();
    xf_hash = stray; xf_hash_vld = 1'b1;
    #1;
    checks++;
    if (xf_hash_rdy !== 1'b0) begin errors++; $display("FAIL stray_rdy: got %0b expected 0", xf_hash_rdy); end
    tick();
    xf_hash_vld = 1'b0;
    #1;
    checks++;
    if (rsp_hash !== 256'd0) begin errors++; $display("FAIL stray_hash: got %0h expected 0", rsp_hash); end
    chunk_offer = 1; hash_auto = 1;
    drive();
    run_until(1, 200, to);
    checks++;
    if (to || exp_rsp.size() != 1 || obs_rsp.size() != 1 || obs_rsp[0].h !== exp_rsp[0].h || obs_rsp[0].h === stray) begin
      errors++; $display("FAIL stray_final: got %0h expected transform hash", rsp_hash);
    end
  endtask

  task automatic test_mid_reset();
    int n;
    bit to;
    do_reset();
    set_job(2, 1);
    drive();
    run_until(1, 100, to);
    checks++;
    if (to || jobs_done !== 32'd1) begin errors++; $display("FAIL midrst_pre: got jobs %0d expected 1", jobs_done); end
    set_job(1, 4);
    drive();
    n = 0;
    while (job_chunks < 2 && n < 100) begin tick(); n++; end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({busy, xf_ctx_vld, xf_chunk_vld, xf_hash_rdy, rsp_vld, req_rdy, req_chunk_rdy} !== 13'b0) begin
      errors++; $display("FAIL midrst_outputs: got %b expected 0", {busy, xf_ctx_vld, xf_chunk_vld, xf_hash_rdy, rsp_vld, req_rdy, req_chunk_rdy});
    end
    checks++;
    if (jobs_done !== 32'd0 || rsp_hash !== 256'd0) begin
      errors++; $display("FAIL midrst_regs: got jobs %0d hash %0h expected 0", jobs_done, rsp_hash);
    end
    do_reset();
    for (int r = 0; r < N; r++) set_job(r, 1);
    drive();
    n = 0;
    while (grant_log.size() == 0 && n < 50) begin tick(); n++; end
    checks++;
    if (grant_log.size() == 0 || grant_log[0] != 0) begin
      errors++; $display("FAIL midrst_grant: got %0d grants first=%0d expected 0", grant_log.size(), (grant_log.size() > 0) ? grant_log[0] : -1);
    end
  endtask

  task automatic test_random();
    bit to;
    do_reset();
    rand_mode = 1; ctx_pol = 1; chunk_pol = 1; rsp_pol = 1;
    run_until(30, 5000, to);
    checks++;
    if (to) begin errors++; $display("FAIL rand_timeout: got %0d responses expected 30", rsp_n); end
    checks++;
    if (obs_rsp.size() != exp_rsp.size()) begin
      errors++; $display("FAIL rand_rsp_count: got %0d expected %0d", obs_rsp.size(), exp_rsp.size());
    end
    for (int i = 0; i < obs_rsp.size() && i < exp_rsp.size(); i++) begin
      checks++;
      if (obs_rsp[i].id != exp_rsp[i].id || obs_rsp[i].h !== exp_rsp[i].h) begin
        errors++; $display("FAIL rand_rsp[%0d]: got id %0d hash %0h expected id %0d hash %0h", i, obs_rsp[i].id, obs_rsp[i].h, exp_rsp[i].id, exp_rsp[i].h);
      end
    end
    for (int i = 0; i < grant_log.size() && i < exp_grant.size(); i++) begin
      checks++;
      if (grant_log[i] != exp_grant[i]) begin
        errors++; $display("FAIL rand_grant[%0d]: got %0d expected %0d", i, grant_log[i], exp_grant[i]);
      end
    end
    checks++;
    if (bad_rdy != 0 || data_err != 0 || stab_err != 0 || early_err != 0) begin
      errors++; $display("FAIL rand_proto: got rdy=%0d data=%0d stab=%0d early=%0d expected 0", bad_rdy, data_err, stab_err, early_err);
    end
    checks++;
    if (jobs_done !== 32'(rsp_n)) begin errors++; $display("FAIL rand_jobs: got %0d expected %0d", jobs_done, rsp_n); end
  endtask

  initial begin
    rst = 1'b1;
    test_reset();
    test_single_job();
    test_fairness();
    test_backpressure();
    test_zero_count();
    test_stray_hash();
    test_mid_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sha256_job_arbiter.md
# sha256_job_arbiter

Round-robin scheduler that shares one `sha256_transform` instance between `NUM_REQ` hashing requesters. It grants one requester at a time and forwards that requester's context, then its chunks, to the transform. It captures the resulting 256-bit hash and returns it on a shared response channel tagged with the requester ID. It sits between the per-lane job generators and the single transform datapath.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..16.
- `ID_W`, `$clog2(NUM_REQ)`: requester ID width.
- `CNT_W`, 8: chunk-count width.
- `clk`  in  1  clock.
- `rst`  in  1  asynchronous, active-high reset.
- `req_vld`  in  NUM_REQ  per-requester job valid (context ready to send).
- `req_rdy`  out  NUM_REQ  per-requester context accepted.
- `req_ctx`  in  NUM_REQ x `sha256_pkg::ShaContext`  initial context per requester.
- `req_nchunks`  in  NUM_REQ x CNT_W  number of 512-bit chunks in the job.
- `req_chunk_vld`  in  NUM_REQ  per-requester chunk valid.
- `req_chunk_rdy`  out  NUM_REQ  per-requester chunk accepted.
- `req_chunk_data`  in  NUM_REQ x [15:0][31:0]  per-requester chunk.
- `xf_ctx_vld` / `xf_ctx_rdy` / `xf_ctx`  out/in/out  1/1/ShaContext  transform context channel.
- `xf_chunk_vld` / `xf_chunk_rdy` / `xf_chunk_data`  out/in/out  1/1/512  transform chunk channel.
- `xf_hash_vld` / `xf_hash_rdy` / `xf_hash`  in/out/in  1/1/256  transform hash channel.
- `rsp_vld`  out  1  result valid.
- `rsp_rdy`  in  1  result accepted.
- `rsp_id`  out  ID_W  requester that owns the result.
- `rsp_hash`  out  256  registered hash.
- `busy`  out  1  state != IDLE.
- `jobs_done`  out  32  count of completed responses.

## Operation
- States: IDLE, CTX, CHUNK, WAIT, RESP.
- **IDLE**
  - If any `req_vld` is high, select a requester round-robin: the lowest index strictly after `last_id`, wrapping modulo NUM_REQ.
  - Latch the selection into `gnt_id`.
  - Latch `cnt` ← `req_nchunks[gnt]`. A value of 0 is clamped to 1.
  - Go to CTX.
- **CTX**
  - `xf_ctx_vld = req_vld[gnt]`, `xf_ctx = req_ctx[gnt]`.
  - `req_rdy[gnt] = xf_ctx_rdy`. All other `req_rdy` bits are 0.
  - On handshake, go to CHUNK.
- **CHUNK**
  - `xf_chunk_vld = req_chunk_vld[gnt]`, data is muxed from `gnt`, `req_chunk_rdy[gnt] = xf_chunk_rdy`. Other bits are 0.
  - Each handshake decrements `cnt`. The handshake taken with `cnt==1` goes to WAIT.
- **WAIT**
  - `xf_hash_rdy = 1`.
  - On `xf_hash_vld`, register the hash into `rsp_hash` and go to RESP.
- **RESP**
  - `rsp_vld = 1`, `rsp_id = gnt_id`.
  - On `rsp_rdy`: `last_id` ← `gnt_id`, `jobs_done` increments (wraps at 2^32), go to IDLE.
- Non-granted requesters see `rdy = 0` and keep their `vld` asserted.
- Requesters hold `req_vld`, `req_ctx` and `req_nchunks` stable until their `req_rdy` handshake. Violating this is undefined.
- `xf_hash_vld` outside WAIT is ignored (`xf_hash_rdy = 0`).
- The arbiter does not inspect `ShaContext` contents. It passes them through unchanged.

## Timing
- Reset (async assert, synchronous-edge deassert release):
  - state = IDLE, `last_id = NUM_REQ-1` (so the first grant goes to requester 0).
  - `gnt_id = 0`, `cnt = 0`, `rsp_hash = 0`, `jobs_done = 0`.
  - All vld/rdy outputs are 0, `busy = 0`.
- A reset in any state aborts the job with no response. The transform must be reset together with the arbiter.
- Request to context: `req_vld` sampled high in IDLE at edge N gives `xf_ctx_vld` high in cycle N+1.
- Hash to response: `xf_hash_vld` at edge M gives `rsp_vld` in cycle M+1.
- Back-to-back jobs: the RESP handshake is followed by at least one IDLE cycle before the next CTX.
- All channel outputs are combinational from registered state plus the granted requester's inputs. There is no combinational path from `rsp_rdy` to `xf_*`.
- Simultaneous requests in IDLE are resolved only by the round-robin pointer. Requests arriving during a job wait for the next IDLE.

## Test plan
- **Single job:** requester 2, `nchunks=3`, all rdy high.
  - Required: exactly one ctx handshake and 3 chunk handshakes to the transform.
  - Required: after `xf_hash=H`, `rsp_vld` appears one cycle later with `rsp_id=2`, `rsp_hash=H`, and `jobs_done=1`.
- **Fairness:** all 4 requesters continuously valid with `nchunks=1`.
  - Required: grant order 0,1,2,3,0,1.
  - Required: every non-granted `req_rdy` and `req_chunk_rdy` stays 0.
- **Backpressure:** `xf_chunk_rdy` toggles 1-0-0-1, `rsp_rdy` is held low for 5 cycles.
  - Required: data is held stable and `cnt` decrements only on handshakes.
  - Required: state stays RESP with `rsp_hash` constant for those 5 cycles.
- **Zero count:** `nchunks=0`.
  - Required: exactly one chunk is forwarded, then WAIT.
- **Stray hash:** `xf_hash_vld` pulsed in CHUNK.
  - Required: `xf_hash_rdy=0` and `rsp_hash` is unchanged.
- **Mid-job reset:** `rst` asserted in CHUNK with `cnt=2`.
  - Required: immediately IDLE and all outputs 0.
  - Required: the next grant goes to requester 0 and `jobs_done=0`.
